window_open_scheduler: RTL

//  Parametrised successor of the single window-open driver. Drives N_WIN windows

---
 rtl/window_open_scheduler_if.sv | 37 +++
 rtl/window_open_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/window_open_scheduler_if.sv
// Interface bundling the sensor/control inputs and the actuator/display outputs
// of window_open_scheduler.
//   active    1      airing enabled
//   mode      1      0 = cooling, 1 = heating
//   win_mask  N_WIN  1 = window installed
//   ETR       TW     external temperature reading
//   RTR       TW     room temperature reading
//   CLR       1      one-cycle close command for window ID_WO
//   LED       2      00 idle, 01 open-cooling, 10 open-heating, 11 fault
//   T_WO      1      a window is currently open
//   ID_WO     ID_W   index of the open / closing window
// master: the control side (drives inputs); slave: the scheduler.
interface window_open_scheduler_if #(
    parameter int TW    = 6,
    parameter int N_WIN = 5,
    parameter int ID_W  = (N_WIN > 1) ? $clog2(N_WIN) : 1
);
    logic             active;
    logic             mode;
    logic [N_WIN-1:0] win_mask;
    logic [TW-1:0]    ETR;
    logic [TW-1:0]    RTR;
    logic             CLR;
    logic [1:0]       LED;
    logic             T_WO;
    logic [ID_W-1:0]  ID_WO;

    modport master (
        output active, mode, win_mask, ETR, RTR,
        input  CLR, LED, T_WO, ID_WO
    );

    modport slave (
        input  active, mode, win_mask, ETR, RTR,
        output CLR, LED, T_WO, ID_WO
    );
endinterface

// File: rtl/window_open_scheduler.sv
// Round-robin window airing scheduler. Opens installed windows one at a time for
// OPEN_CYC cycles while outside air helps the selected mode (cooling or heating),
// with hysteresis, qualification debounce and a sensor-fault state.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   window_open_scheduler_if.slave (active, mode, win_mask, ETR, RTR in;
//         CLR, LED, T_WO, ID_WO out, all registered)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | all windows closed, counting consecutive qualifying cycles
// S_OPEN  | window ID_WO open, open timer counting down
// S_CLOSE | one-cycle close pulse for ID_WO, pointer advanced past it
// S_FAULT | reading out of range, waiting for STABLE_CYC clean cycles
module window_open_scheduler #(
    parameter int TW         = 6,
    parameter int N_WIN      = 5,
    parameter int HYST       = 2,
    parameter int STABLE_CYC = 4,
    parameter int OPEN_CYC   = 10,
    parameter int T_MAX      = 50
) (
    input  logic                   clk,
    input  logic                   rst,
    window_open_scheduler_if.slave bus
);
    localparam int ID_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
    localparam int QW   = $clog2(STABLE_CYC + 1);
    localparam int OW   = $clog2(OPEN_CYC + 1);

    localparam logic [TW:0]   HYST_W   = (TW + 1)'(HYST);
    localparam logic [TW:0]   T_MAX_W  = (TW + 1)'(T_MAX);
    localparam logic [QW-1:0] STABLE_V = QW'(STABLE_CYC);
    localparam logic [OW-1:0] OPEN_V   = OW'(OPEN_CYC);
    localparam logic [OW-1:0] OW_ONE   = OW'(1);

    localparam logic [1:0] LED_IDLE  = 2'b00;
    localparam logic [1:0] LED_COOL  = 2'b01;
    localparam logic [1:0] LED_HEAT  = 2'b10;
    localparam logic [1:0] LED_FAULT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_CLOSE,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [OW-1:0]   timer_q, timer_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            clr_q, clr_d;
    logic [1:0]      led_q, led_d;
    logic            t_wo_q, t_wo_d;
    logic [ID_W-1:0] id_wo_q, id_wo_d;

    logic [TW:0]     etr_w, rtr_w;
    logic            cond, qual, fault, cur_inst;
    logic [1:0]      led_mode;
    logic [QW-1:0]   qcnt_inc;
    logic [N_WIN-1:0] rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   idx_sum;
    logic [ID_W-1:0] nxt_idx;
    logic [ID_W-1:0] ptr_wrap;

    // Widen by one bit so RTR+HYST / ETR+HYST cannot overflow.
    assign etr_w = {1'b0, bus.ETR};
    assign rtr_w = {1'b0, bus.RTR};

    assign cond  = bus.mode ? (etr_w >= (rtr_w + HYST_W))
                            : ((etr_w + HYST_W) <= rtr_w);
    assign qual  = bus.active & cond & (|bus.win_mask);
    assign fault = (etr_w > T_MAX_W) | (rtr_w > T_MAX_W);

    assign led_mode = bus.mode ? LED_HEAT : LED_COOL;
    assign qcnt_inc = qcnt_q + QW'(1);

    // Shift avoids indexing win_mask with an ID that may exceed N_WIN-1.
    assign cur_inst = |(bus.win_mask & (N_WIN'(1) << id_wo_q));

    assign ptr_wrap = (id_wo_q == ID_W'(N_WIN - 1)) ? '0 : (id_wo_q + ID_W'(1));

    // Round-robin pick: rotate the mask so bit 0 is the pointer position, find
    // the lowest set bit, then rotate the offset back into window space.
    always_comb begin
        rot = N_WIN'({bus.win_mask, bus.win_mask} >> ptr_q);
        off = '0;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        idx_sum = {1'b0, ptr_q} + {1'b0, off};
        if (idx_sum >= (ID_W + 1)'(N_WIN)) begin
            idx_sum = idx_sum - (ID_W + 1)'(N_WIN);
        end
        nxt_idx = idx_sum[ID_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            timer_q <= '0;
            ptr_q   <= '0;
            clr_q   <= 1'b0;
            led_q   <= LED_IDLE;
            t_wo_q  <= 1'b0;
            id_wo_q <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            clr_q   <= clr_d;
            led_q   <= led_d;
            t_wo_q  <= t_wo_d;
            id_wo_q <= id_wo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        clr_d   = 1'b0;
        led_d   = led_q;
        t_wo_d  = t_wo_q;
        id_wo_d = id_wo_q;

        if (fault) begin
            // Fault overrides every transition; only an open window gets closed.
            state_d = S_FAULT;
            qcnt_d  = '0;
            clr_d   = (state_q == S_OPEN);
            t_wo_d  = 1'b0;
            led_d   = LED_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    led_d  = LED_IDLE;
                    t_wo_d = 1'b0;
                    if (qual) begin
                        if (qcnt_inc == STABLE_V) begin
                            qcnt_d  = '0;
                            state_d = S_OPEN;
                            timer_d = OPEN_V;
                            id_wo_d = nxt_idx;
                            t_wo_d  = 1'b1;
                            led_d   = led_mode;
                        end else begin
                            qcnt_d = qcnt_inc;
                        end
                    end else begin
                        qcnt_d = '0;
                    end
                end

                S_OPEN: begin
                    // Timer reaches 0 exactly on the edge that ends the OPEN_CYC-th cycle.
                    timer_d = timer_q - OW_ONE;
                    if ((timer_q == OW_ONE) || !qual || !cur_inst) begin
                        state_d = S_CLOSE;
                        clr_d   = 1'b1;
                        t_wo_d  = 1'b0;
                        ptr_d   = ptr_wrap;
                    end else begin
                        led_d = led_mode;
                    end
                end

                S_CLOSE: begin
                    // A zero timer means the window ran its full time, so the
                    // next one opens directly without requalifying.
                    if (qual && (timer_q == '0)) begin
                        state_d = S_OPEN;
                        timer_d = OPEN_V;
                        id_wo_d = nxt_idx;
                        t_wo_d  = 1'b1;
                        led_d   = led_mode;
                    end else begin
                        state_d = S_IDLE;
                        qcnt_d  = '0;
                        led_d   = LED_IDLE;
                        t_wo_d  = 1'b0;
                    end
                end

                S_FAULT: begin
                    t_wo_d = 1'b0;
                    led_d  = LED_FAULT;
                    if (qcnt_inc == STABLE_V) begin
                        state_d = S_IDLE;
                        qcnt_d  = '0;
                        led_d   = LED_IDLE;
                    end else begin
                        qcnt_d = qcnt_inc;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.CLR   = clr_q;
    assign bus.LED   = led_q;
    assign bus.T_WO  = t_wo_q;
    assign bus.ID_WO = id_wo_q;
endmodule
